qspi_flash_sequencer: RTL and testbench

//  Host-facing controller that sequences qspi_serializer through complete SPI-NOR operations:

---
 rtl/qspi_flash_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_qspi_flash_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_flash_sequencer.sv
// qspi_flash_sequencer: drives a qspi_serializer through complete SPI-NOR
// operations (READ 0x03, 4K ERASE 0x06+0x20, PAGE PROGRAM 0x06+0x02), polling
// RDSR (0x05) until WIP clears for erase/program.
// Optional feature macro: QSPI_SEQ_TIMEOUT_EN (poll timeout with rsp_err).
module qspi_flash_sequencer #(
    parameter int GAP_CYCLES     = 8,
    parameter int POLL_INTERVAL  = 64,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        seq_busy,
    output logic        ser_start,
    output logic [7:0]  ser_cmd,
    output logic [31:0] ser_addr,
    output logic        ser_addr_en,
    output logic        ser_data_en,
    output logic [1:0]  ser_data_size,
    output logic        ser_wr,
    output logic        ser_en_write,
    output logic [31:0] ser_wdata,
    input  logic        ser_busy,
    input  logic        ser_dataready,
    input  logic [31:0] ser_rdata
);
    typedef enum logic [2:0] {IDLE, ISSUE, GAP, POLL_WAIT, RESP} state_t;

    localparam int CNT_MAX = (GAP_CYCLES > POLL_INTERVAL) ? GAP_CYCLES : POLL_INTERVAL;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] POLL_LOAD = CW'(POLL_INTERVAL);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_PROG = 2'b10;
    localparam logic [1:0] OP_BAD  = 2'b11;

    state_t          state, state_nx;
    logic [1:0]      op;
    logic [23:0]     addr;
    logic [31:0]     wdata;
    logic [1:0]      step;
    logic [CW-1:0]   cnt;
    logic            err;
    logic            idle_done;

    logic [7:0]      st_cmd;
    logic            st_addr_en, st_data_en, st_wr, st_poll;
    logic [1:0]      st_size;

    // Deselect window ends after the counter has seen enough consecutive idle cycles
    assign idle_done = !ser_busy && (cnt == CNT_ONE);

`ifdef QSPI_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0] tcnt;
    logic          timed_out;
    assign timed_out = (tcnt >= T_LIM);

    // Poll budget: cleared while idle, saturates at the limit
    always_ff @(posedge clk) begin
        if (!rst_n)
            tcnt <= '0;
        else if (state == IDLE)
            tcnt <= '0;
        else if (((state == ISSUE && st_poll) || state == POLL_WAIT) && !timed_out)
            tcnt <= tcnt + TW'(1);
    end
`else
    logic timed_out;
    assign timed_out = 1'b0;
`endif

    // Decode the current step of the captured operation into serializer fields
    always_comb begin
        st_cmd     = 8'h00;
        st_addr_en = 1'b0;
        st_data_en = 1'b0;
        st_wr      = 1'b0;
        st_poll    = 1'b0;
        st_size    = 2'b00;
        if (op == OP_READ) begin
            st_cmd     = 8'h03;
            st_addr_en = 1'b1;
            st_data_en = 1'b1;
            st_size    = 2'b11;
        end else begin
            case (step)
                2'd0: st_cmd = 8'h06;
                2'd1: begin
                    st_cmd     = (op == OP_PROG) ? 8'h02 : 8'h20;
                    st_addr_en = 1'b1;
                    st_data_en = (op == OP_PROG);
                    st_wr      = (op == OP_PROG);
                    st_size    = (op == OP_PROG) ? 2'b11 : 2'b00;
                end
                default: begin
                    st_cmd     = 8'h05;
                    st_data_en = 1'b1;
                    st_poll    = 1'b1;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (req_valid) state_nx = (req_op == OP_BAD) ? RESP : ISSUE;
            ISSUE:     if (ser_dataready) begin
                           if (op == OP_READ)  state_nx = RESP;
                           else if (st_poll)   state_nx = ser_rdata[0] ? POLL_WAIT : RESP;
                           else                state_nx = GAP;
                       end
            GAP:       if (idle_done) state_nx = ISSUE;
            POLL_WAIT: if (timed_out) state_nx = RESP;
                       else if (idle_done) state_nx = ISSUE;
            RESP:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Request capture, step/counter sequencing and read-data latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op        <= 2'b00;
            addr      <= 24'h0;
            wdata     <= 32'h0;
            step      <= 2'd0;
            cnt       <= '0;
            err       <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op    <= req_op;
                    addr  <= req_addr;
                    wdata <= req_wdata;
                    step  <= 2'd0;
                    err   <= (req_op == OP_BAD);
                end
                ISSUE: if (ser_dataready) begin
                    if (op == OP_READ) rsp_rdata <= ser_rdata;
                    cnt <= st_poll ? POLL_LOAD : GAP_LOAD;
                end
                GAP: begin
                    if (ser_busy)            cnt  <= GAP_LOAD;
                    else if (cnt == CNT_ONE) step <= step + 2'd1;
                    else                     cnt  <= cnt - CNT_ONE;
                end
                POLL_WAIT: begin
                    if (timed_out)           err <= 1'b1;
                    else if (ser_busy)       cnt <= POLL_LOAD;
                    else if (cnt != CNT_ONE) cnt <= cnt - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    // Outputs: serializer fields only presented while issuing
    always_comb begin
        req_ready     = (state == IDLE);
        seq_busy      = (state != IDLE);
        rsp_valid     = (state == RESP);
        rsp_err       = (state == RESP) && err;
        ser_start     = (state == ISSUE);
        ser_cmd       = (state == ISSUE) ? st_cmd : 8'h00;
        ser_addr_en   = (state == ISSUE) && st_addr_en;
        ser_data_en   = (state == ISSUE) && st_data_en;
        ser_data_size = (state == ISSUE) ? st_size : 2'b00;
        ser_wr        = (state == ISSUE) && st_wr;
        ser_en_write  = (state == ISSUE) && st_wr;
        ser_addr      = {8'h00, addr};
        ser_wdata     = wdata;
    end
endmodule

// File: tb/tb_qspi_flash_sequencer.sv
// Bench for qspi_flash_sequencer: behavioural serializer + SPI-NOR flash model,
// transaction and response scoreboards. Honors QSPI_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_qspi_flash_sequencer;
    localparam int GAP  = 8;
    localparam int POLL = 64;
    localparam int TOUT = 2000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [23:0] req_addr = 24'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid, rsp_err, seq_busy;
    logic [31:0] rsp_rdata;
    logic        ser_start, ser_addr_en, ser_data_en, ser_wr, ser_en_write;
    logic [7:0]  ser_cmd;
    logic [31:0] ser_addr, ser_wdata;
    logic [1:0]  ser_data_size;
    logic        ser_busy = 1'b0, ser_dataready = 1'b0;
    logic [31:0] ser_rdata = 32'h0;

    qspi_flash_sequencer #(.GAP_CYCLES(GAP), .POLL_INTERVAL(POLL), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .seq_busy(seq_busy),
        .ser_start(ser_start), .ser_cmd(ser_cmd), .ser_addr(ser_addr), .ser_addr_en(ser_addr_en),
        .ser_data_en(ser_data_en), .ser_data_size(ser_data_size), .ser_wr(ser_wr),
        .ser_en_write(ser_en_write), .ser_wdata(ser_wdata), .ser_busy(ser_busy),
        .ser_dataready(ser_dataready), .ser_rdata(ser_rdata)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0;
    int req_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] cmd; logic ae, de, wr; logic [1:0] sz; logic [23:0] addr; bit gap; } tx_t;
    typedef struct { logic [31:0] rdata; logic err; bit chk_rd; int lat; } rsp_t;
    tx_t  txq[$];
    rsp_t rspq[$];
    bit   poll_any = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- serializer + flash model ----------------
    int          sc = 0, tail = 0, fall_cyc = 0;
    logic [7:0]  cur_cmd;
    logic [23:0] cur_addr;
    logic [31:0] cur_wdata;
    bit          wel = 0, wip_stuck = 0;
    int          wip_cnt = 0;
    int          erase_polls = 3, prog_polls = 2;
    logic [31:0] mem [int];

    task automatic push_tx(logic [7:0] c, logic ae, logic de, logic wr, logic [1:0] sz,
                           logic [23:0] a, bit g);
        tx_t t;
        t.cmd = c; t.ae = ae; t.de = de; t.wr = wr; t.sz = sz; t.addr = a; t.gap = g;
        txq.push_back(t);
    endtask

    task automatic push_rsp(logic [31:0] d, logic e, bit cr, int lat);
        rsp_t r;
        r.rdata = d; r.err = e; r.chk_rd = cr; r.lat = lat;
        rspq.push_back(r);
    endtask

    task automatic tx_check();
        tx_t e;
        if (txq.size() == 0) begin
            if (poll_any) begin
                chk("poll_cmd", ser_cmd, 8'h05);
                chk("poll_size", ser_data_size, 2'b00);
                chk("poll_gap", (cyc - fall_cyc) >= GAP, 1);
            end else begin
                total++; bad++;
                $display("FAIL unexpected_tx: got cmd %h, want no transaction", ser_cmd);
            end
            return;
        end
        e = txq.pop_front();
        chk("tx_cmd", ser_cmd, e.cmd);
        chk("tx_addr_en", ser_addr_en, e.ae);
        chk("tx_data_en", ser_data_en, e.de);
        chk("tx_size", ser_data_size, e.sz);
        chk("tx_wr", ser_wr, e.wr);
        chk("tx_en_write", ser_en_write, e.wr);
        if (e.ae) chk("tx_addr", ser_addr, {8'h00, e.addr});
        if (e.gap) chk("tx_gap", (cyc - fall_cyc) >= GAP, 1);
    endtask

    task automatic flash_exec();
        case (cur_cmd)
            8'h06: begin wel = 1; ser_rdata = 32'h0; end
            8'h03: ser_rdata = mem.exists(int'(cur_addr)) ? mem[int'(cur_addr)] : 32'hFFFF_FFFF;
            8'h02: if (wel) begin mem[int'(cur_addr)] = cur_wdata; wel = 0; wip_cnt = prog_polls; end
            8'h20: if (wel) begin wel = 0; wip_cnt = erase_polls; end
            8'h05: begin
                ser_rdata = {24'hA5A5A5, 6'b111111, wel, (wip_stuck || wip_cnt > 0)};
                if (wip_cnt > 0) wip_cnt--;
            end
            default: ser_rdata = 32'h0;
        endcase
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            ser_busy = 0; ser_dataready = 0; sc = 0; tail = 0;
        end else if (ser_dataready) begin
            ser_dataready = 0; tail = 2;
        end else if (tail > 0) begin
            tail--;
            if (tail == 0) begin ser_busy = 0; fall_cyc = cyc; end
        end else if (ser_busy) begin
            sc--;
            if (sc == 0) begin flash_exec(); ser_dataready = 1; end
        end else if (ser_start === 1'b1) begin
            tx_check();
            cur_cmd = ser_cmd; cur_addr = ser_addr[23:0]; cur_wdata = ser_wdata;
            ser_busy = 1; sc = 5;
        end
    end

    // ---------------- response monitor ----------------
    bit   prev_rv = 0;
    rsp_t r;
    always @(negedge clk) begin
        if (rst_n && rsp_valid === 1'b1) begin
            chk("rsp_pulse_width", prev_rv, 0);
            chk("rsp_ready_low", req_ready, 0);
            if (rspq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_rsp: got rsp_valid err=%b, want none", rsp_err);
            end else begin
                r = rspq.pop_front();
                chk("rsp_err", rsp_err, r.err);
                if (r.chk_rd) chk("rsp_rdata", rsp_rdata, r.rdata);
                if (r.lat >= 0) chk("rsp_latency", cyc - req_cyc, r.lat);
            end
        end
        prev_rv = (rsp_valid === 1'b1);
    end

    // ---------------- stimulus ----------------
    task automatic do_req(logic [1:0] op, logic [23:0] a, logic [31:0] d);
        int n = 0;
        while (req_ready !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) begin total++; bad++; $display("FAIL req_ready_wait: got 0, want 1"); end
        req_valid = 1; req_op = op; req_addr = a; req_wdata = d; req_cyc = cyc;
        @(negedge clk);
        req_valid = 0; req_op = 2'b01; req_addr = 24'hFFFFFF; req_wdata = 32'h0BAD_0BAD;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((rspq.size() != 0 || txq.size() != 0 || req_ready !== 1'b1) && n < budget) begin
            @(negedge clk); n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d rsp/%0d tx pending, want 0", rspq.size(), txq.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[32'h100] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_seq_busy", seq_busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_ser_start", ser_start, 0);
        chk("rst_ser_cmd", ser_cmd, 0);
        chk("rst_ser_addr", ser_addr, 0);
        rst_n = 1;
        @(negedge clk);

        // READ; a stray request while busy must be ignored
        push_tx(8'h03, 1, 1, 0, 2'b11, 24'h000100, 0);
        push_rsp(32'hDEADBEEF, 0, 1, -1);
        do_req(2'b00, 24'h000100, 32'h0);
        req_valid = 1; req_op = 2'b11;
        repeat (3) @(negedge clk);
        req_valid = 0;
        drain(2000);

        // ERASE: WIP high for 3 polls
        push_tx(8'h06, 0, 0, 0, 2'b00, 24'h0, 0);
        push_tx(8'h20, 1, 0, 0, 2'b00, 24'h001000, 1);
        repeat (4) push_tx(8'h05, 0, 1, 0, 2'b00, 24'h0, 1);
        push_rsp(32'h0, 0, 0, -1);
        do_req(2'b01, 24'h001000, 32'h0);
        drain(5000);

        // PROGRAM then READ back
        push_tx(8'h06, 0, 0, 0, 2'b00, 24'h0, 0);
        push_tx(8'h02, 1, 1, 1, 2'b11, 24'h000000, 1);
        repeat (3) push_tx(8'h05, 0, 1, 0, 2'b00, 24'h0, 1);
        push_rsp(32'h0, 0, 0, -1);
        do_req(2'b10, 24'h000000, 32'h12345678);
        drain(5000);
        push_tx(8'h03, 1, 1, 0, 2'b11, 24'h000000, 0);
        push_rsp(32'h12345678, 0, 1, -1);
        do_req(2'b00, 24'h000000, 32'h0);
        drain(2000);

        // Illegal op: error response one cycle after accept, no flash traffic
        push_rsp(32'h0, 1, 0, 1);
        do_req(2'b11, 24'h000200, 32'h0);
        drain(100);
        chk("rdata_hold_after_err", rsp_rdata, 32'h12345678);

        // Reset during PROGRAM poll
        wip_stuck = 1;
        push_tx(8'h06, 0, 0, 0, 2'b00, 24'h0, 0);
        push_tx(8'h02, 1, 1, 1, 2'b11, 24'h000040, 1);
        push_tx(8'h05, 0, 1, 0, 2'b00, 24'h0, 1);
        do_req(2'b10, 24'h000040, 32'hCAFEF00D);
        begin
            int n = 0;
            while (!(ser_start === 1'b1 && ser_cmd == 8'h05) && n < 3000) begin @(negedge clk); n++; end
            chk("reach_poll", n < 3000, 1);
        end
        repeat (2) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk("abort_ser_start", ser_start, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1;
        wip_stuck = 0; wip_cnt = 0;
        @(negedge clk);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_tx_left", txq.size(), 0);
        push_tx(8'h03, 1, 1, 0, 2'b11, 24'h000040, 0);
        push_rsp(32'hCAFEF00D, 0, 1, -1);
        do_req(2'b00, 24'h000040, 32'h0);
        drain(2000);

        // WIP stuck high
        wip_stuck = 1;
        push_tx(8'h06, 0, 0, 0, 2'b00, 24'h0, 0);
        push_tx(8'h20, 1, 0, 0, 2'b00, 24'h002000, 1);
        poll_any = 1;
`ifdef QSPI_SEQ_TIMEOUT_EN
        push_rsp(32'h0, 1, 0, -1);
        do_req(2'b01, 24'h002000, 32'h0);
        drain(10000);
`else
        do_req(2'b01, 24'h002000, 32'h0);
        repeat (4000) @(negedge clk);
        chk("stuck_still_busy", seq_busy, 1);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
`endif
        poll_any = 0; wip_stuck = 0; wip_cnt = 0;
        chk("end_rsp_left", rspq.size(), 0);
        chk("end_tx_left", txq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
